// File: rtl/lpc_pkg.sv
// lpc_pkg: shared constants for the LPC host sequencer.
// Phase codes, LAD nibble codes and SYNC codes.
package lpc_pkg;

    typedef logic [3:0] lpc_state_t;

    localparam lpc_state_t ST_IDLE  = 4'd0;
    localparam lpc_state_t ST_START = 4'd1;
    localparam lpc_state_t ST_CTDIR = 4'd2;
    localparam lpc_state_t ST_ADDR  = 4'd3;
    localparam lpc_state_t ST_WDATA = 4'd4;
    localparam lpc_state_t ST_TAR1  = 4'd5;
    localparam lpc_state_t ST_TAR2  = 4'd6;
    localparam lpc_state_t ST_SYNC  = 4'd7;
    localparam lpc_state_t ST_RDATA = 4'd8;
    localparam lpc_state_t ST_PTAR1 = 4'd9;
    localparam lpc_state_t ST_PTAR2 = 4'd10;
    localparam lpc_state_t ST_ABORT = 4'd11;

    localparam logic [3:0] CT_IO_RD  = 4'b0000;
    localparam logic [3:0] CT_IO_WR  = 4'b0010;
    localparam logic [3:0] CT_MEM_RD = 4'b0100;
    localparam logic [3:0] CT_MEM_WR = 4'b0110;

    localparam logic [3:0] NIB_START = 4'b0000;
    localparam logic [3:0] NIB_ABORT = 4'b1111;

    localparam logic [3:0] SYNC_READY      = 4'b0000;
    localparam logic [3:0] SYNC_SHORT_WAIT = 4'b0101;
    localparam logic [3:0] SYNC_LONG_WAIT  = 4'b0110;
    localparam logic [3:0] SYNC_ERROR      = 4'b1010;

    function automatic logic [3:0] cyctype_dir(input logic mem,
                                               input logic write);
        return {1'b0, mem, write, 1'b0};
    endfunction

endpackage

// File: rtl/lpc_rr_arbiter.sv
// lpc_rr_arbiter: two-way round-robin grant.
// Requester 0 wins the first contention after reset.
module lpc_rr_arbiter
    import lpc_pkg::*;
(
    input  logic       lpc_clock,
    input  logic       lpc_reset,
    input  logic [1:0] req_valid,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       grant_id
);

    logic last_grant;

    // Grant the lone requester, or the one not served last.
    always_comb begin
        grant = 2'b00;
        unique case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign grant_id = grant[1];

    // Remember who was accepted last.
    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset)
            last_grant <= 1'b1;
        else if (accept)
            last_grant <= grant_id;
    end

endmodule

// File: rtl/lpc_host_sequencer.sv
// lpc_host_sequencer: two-requester LPC host cycle sequencer.
// Drives I/O and memory read/write cycles on LAD/LFRAME#.
module lpc_host_sequencer
    import lpc_pkg::*;
#(
    parameter int SYNC_TIMEOUT = 32
) (
    input  logic        lpc_clock,
    input  logic        lpc_reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_mem,
    input  logic [1:0]  req_write,
    input  logic [63:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic [3:0]  lpc_ad_in,
    output logic [3:0]  lpc_ad_out,
    output logic        lpc_ad_oe,
    output logic        lpc_frame,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err
);

    localparam int TW = $clog2(SYNC_TIMEOUT);

    lpc_state_t    state, nxt_state;
    logic [2:0]    cnt, nxt_cnt;
    logic [TW-1:0] tmo, nxt_tmo;
    logic [1:0]    grant;
    logic          grant_id;
    logic          accept;
    logic          cur_id, cur_mem, cur_write;
    logic [31:0]   cur_addr;
    logic [7:0]    cur_wdata;
    logic [7:0]    rdata;
    logic          err;
    logic [2:0]    addr_last, addr_idx;
    logic          sync_done, sync_wait;
    logic [3:0]    d_ad;
    logic          d_oe, d_frame;

    lpc_rr_arbiter u_arb (
        .lpc_clock (lpc_clock),
        .lpc_reset (lpc_reset),
        .req_valid (req_valid),
        .accept    (accept),
        .grant     (grant),
        .grant_id  (grant_id)
    );

    assign req_ready = (state == ST_IDLE) ? grant : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign addr_last = cur_mem ? 3'd7 : 3'd3;
    assign addr_idx  = addr_last - nxt_cnt;
    assign sync_done = (lpc_ad_in == SYNC_READY) ||
                       (lpc_ad_in == SYNC_ERROR);
    assign sync_wait = (lpc_ad_in == SYNC_SHORT_WAIT) ||
                       (lpc_ad_in == SYNC_LONG_WAIT);

    // Phase sequencing, nibble counting and SYNC timeout.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_tmo   = tmo;
        unique case (state)
            ST_IDLE:  if (accept) nxt_state = ST_START;
            ST_START: nxt_state = ST_CTDIR;
            ST_CTDIR: begin
                nxt_state = ST_ADDR;
                nxt_cnt   = '0;
            end
            ST_ADDR: begin
                if (cnt == addr_last) begin
                    nxt_cnt   = '0;
                    nxt_state = cur_write ? ST_WDATA : ST_TAR1;
                end else begin
                    nxt_cnt = cnt + 3'd1;
                end
            end
            ST_WDATA: begin
                if (cnt[0]) begin
                    nxt_cnt   = '0;
                    nxt_state = ST_TAR1;
                end else begin
                    nxt_cnt = cnt + 3'd1;
                end
            end
            ST_TAR1:  nxt_state = ST_TAR2;
            ST_TAR2: begin
                nxt_state = ST_SYNC;
                nxt_tmo   = '0;
            end
            ST_SYNC: begin
                if (sync_done) begin
                    nxt_cnt   = '0;
                    nxt_state = cur_write ? ST_PTAR1 : ST_RDATA;
                end else if (!sync_wait) begin
                    if (tmo == TW'(SYNC_TIMEOUT - 1)) begin
                        nxt_cnt   = '0;
                        nxt_state = ST_ABORT;
                    end else begin
                        nxt_tmo = tmo + 1'b1;
                    end
                end
            end
            ST_RDATA: begin
                if (cnt[0]) begin
                    nxt_cnt   = '0;
                    nxt_state = ST_PTAR1;
                end else begin
                    nxt_cnt = cnt + 3'd1;
                end
            end
            ST_PTAR1: nxt_state = ST_PTAR2;
            ST_PTAR2: nxt_state = ST_IDLE;
            ST_ABORT: begin
                if (cnt == 3'd3)
                    nxt_state = ST_IDLE;
                else
                    nxt_cnt = cnt + 3'd1;
            end
            default:  nxt_state = ST_IDLE;
        endcase
    end

    // Bus pin values for the phase entered at the next edge.
    always_comb begin
        d_frame = 1'b1;
        d_oe    = 1'b0;
        d_ad    = NIB_ABORT;
        unique case (nxt_state)
            ST_START: begin
                d_frame = 1'b0;
                d_oe    = 1'b1;
                d_ad    = NIB_START;
            end
            ST_CTDIR: begin
                d_oe = 1'b1;
                d_ad = cyctype_dir(cur_mem, cur_write);
            end
            ST_ADDR: begin
                d_oe = 1'b1;
                d_ad = cur_addr[{addr_idx, 2'b00} +: 4];
            end
            ST_WDATA: begin
                d_oe = 1'b1;
                d_ad = nxt_cnt[0] ? cur_wdata[7:4] : cur_wdata[3:0];
            end
            ST_TAR1:  d_oe = 1'b1;
            ST_ABORT: begin
                d_frame = 1'b0;
                d_oe    = 1'b1;
            end
            default: ;
        endcase
    end

    // State and registered bus pins.
    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            tmo        <= '0;
            lpc_frame  <= 1'b1;
            lpc_ad_out <= NIB_ABORT;
            lpc_ad_oe  <= 1'b0;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            tmo        <= nxt_tmo;
            lpc_frame  <= d_frame;
            lpc_ad_out <= d_ad;
            lpc_ad_oe  <= d_oe;
        end
    end

    // Latch the accepted request and collect SYNC/read results.
    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            cur_id    <= 1'b0;
            cur_mem   <= 1'b0;
            cur_write <= 1'b0;
            cur_addr  <= '0;
            cur_wdata <= '0;
            err       <= 1'b0;
            rdata     <= '0;
        end else begin
            if (accept) begin
                cur_id    <= grant_id;
                cur_mem   <= req_mem[grant_id];
                cur_write <= req_write[grant_id];
                cur_addr  <= grant_id ? req_addr[63:32] : req_addr[31:0];
                cur_wdata <= grant_id ? req_wdata[15:8] : req_wdata[7:0];
                err       <= 1'b0;
                rdata     <= '0;
            end
            if (state == ST_SYNC && lpc_ad_in == SYNC_ERROR)
                err <= 1'b1;
            if (state == ST_RDATA) begin
                if (cnt[0])
                    rdata[7:4] <= lpc_ad_in;
                else
                    rdata[3:0] <= lpc_ad_in;
            end
        end
    end

    // One-cycle completion pulse; fields hold until the next one.
    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (state == ST_PTAR2) begin
                rsp_valid <= 1'b1;
                rsp_id    <= cur_id;
                rsp_err   <= err;
                rsp_rdata <= cur_write ? 8'h00 : rdata;
            end else if (state == ST_ABORT && cnt == 3'd3) begin
                rsp_valid <= 1'b1;
                rsp_id    <= cur_id;
                rsp_err   <= 1'b1;
                rsp_rdata <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_lpc_host_sequencer.sv
// tb_lpc_host_sequencer: randomized bench with a per-cycle
// LPC trace model built from request fields and SYNC scripts.
module tb_lpc_host_sequencer;
    import lpc_pkg::*;

    localparam int TMO = 32;

    logic        lpc_clock = 1'b0;
    logic        lpc_reset;
    logic [1:0]  req_valid, req_ready, req_mem, req_write;
    logic [63:0] req_addr;
    logic [15:0] req_wdata;
    logic [3:0]  lpc_ad_in, lpc_ad_out;
    logic        lpc_ad_oe, lpc_frame;
    logic        rsp_valid, rsp_id, rsp_err;
    logic [7:0]  rsp_rdata;

    lpc_host_sequencer #(.SYNC_TIMEOUT(TMO)) dut (
        .lpc_clock  (lpc_clock),
        .lpc_reset  (lpc_reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_mem    (req_mem),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .lpc_ad_in  (lpc_ad_in),
        .lpc_ad_out (lpc_ad_out),
        .lpc_ad_oe  (lpc_ad_oe),
        .lpc_frame  (lpc_frame),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 lpc_clock = ~lpc_clock;

    int total = 0;
    int bad   = 0;

    logic        pend   [2];
    logic        m_mem  [2];
    logic        m_wr   [2];
    logic [31:0] m_addr [2];
    logic [7:0]  m_wd   [2];
    logic        m_last;

    logic [5:0]  exp_q  [$];
    logic [3:0]  in_q   [$];
    logic [3:0]  sync_q [$];
    logic [3:0]  rd0, rd1;
    logic        exp_err;
    logic [7:0]  exp_rdata;
    logic        h_id, h_err;
    logic [7:0]  h_rdata;

    logic [3:0]  other_tab [12] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'h8,
                                    4'h9, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic apply_reqs();
        req_valid = {pend[1], pend[0]};
        req_mem   = {m_mem[1], m_mem[0]};
        req_write = {m_wr[1], m_wr[0]};
        req_addr  = {m_addr[1], m_addr[0]};
        req_wdata = {m_wd[1], m_wd[0]};
    endtask

    task automatic set_req(input int g, input logic mem, input logic wr,
                           input logic [31:0] a, input logic [7:0] d);
        pend[g]   = 1'b1;
        m_mem[g]  = mem;
        m_wr[g]   = wr;
        m_addr[g] = a;
        m_wd[g]   = d;
    endtask

    function automatic logic [5:0] bus_now();
        return {lpc_frame, lpc_ad_oe, lpc_ad_oe ? lpc_ad_out : 4'h0};
    endfunction

    function automatic void push(input logic f, input logic o,
                                 input logic [3:0] a, input logic [3:0] i);
        exp_q.push_back({f, o, o ? a : 4'h0});
        in_q.push_back(i);
    endfunction

    // Whole-cycle expectation: one entry per bus clock from START to PTAR2.
    function automatic void build(input int g);
        int   n;
        int   others;
        logic abort;
        logic [3:0] c;
        exp_q.delete();
        in_q.delete();
        others  = 0;
        abort   = 1'b0;
        exp_err = 1'b0;
        push(1'b0, 1'b1, 4'h0, 4'hF);
        push(1'b1, 1'b1, {1'b0, m_mem[g], m_wr[g], 1'b0}, 4'hF);
        n = m_mem[g] ? 8 : 4;
        for (int i = n - 1; i >= 0; i--)
            push(1'b1, 1'b1, m_addr[g][4*i +: 4], 4'hF);
        if (m_wr[g]) begin
            push(1'b1, 1'b1, m_wd[g][3:0], 4'hF);
            push(1'b1, 1'b1, m_wd[g][7:4], 4'hF);
        end
        push(1'b1, 1'b1, 4'hF, 4'hF);
        push(1'b1, 1'b0, 4'hF, 4'hF);
        for (int i = 0; i < sync_q.size(); i++) begin
            c = sync_q[i];
            push(1'b1, 1'b0, 4'hF, c);
            if (c == 4'h0 || c == 4'hA) begin
                exp_err = (c == 4'hA);
                break;
            end
            if (c != 4'h5 && c != 4'h6) begin
                others++;
                if (others == TMO) begin
                    abort = 1'b1;
                    break;
                end
            end
        end
        if (abort) begin
            for (int i = 0; i < 4; i++)
                push(1'b0, 1'b1, 4'hF, 4'hF);
            exp_err   = 1'b1;
            exp_rdata = 8'h00;
        end else begin
            if (!m_wr[g]) begin
                push(1'b1, 1'b0, 4'hF, rd0);
                push(1'b1, 1'b0, 4'hF, rd1);
                exp_rdata = {rd1, rd0};
            end else begin
                exp_rdata = 8'h00;
            end
            push(1'b1, 1'b0, 4'hF, 4'hF);
            push(1'b1, 1'b0, 4'hF, 4'hF);
        end
    endfunction

    task automatic random_sync();
        int n;
        int r;
        sync_q.delete();
        n = $urandom_range(0, 4);
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 2);
            if (r == 0)
                sync_q.push_back(4'h5);
            else if (r == 1)
                sync_q.push_back(4'h6);
            else
                sync_q.push_back(other_tab[$urandom_range(0, 11)]);
        end
        sync_q.push_back(($urandom_range(0, 3) == 0) ? 4'hA : 4'h0);
        rd0 = 4'($urandom_range(0, 15));
        rd1 = 4'($urandom_range(0, 15));
    endtask

    task automatic random_req(input int g);
        set_req(g, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom, 8'($urandom_range(0, 255)));
    endtask

    // Waits for an accept, then walks the expected trace cycle by cycle.
    task automatic run_txn(input int kill_at);
        logic got;
        logic g;
        logic exp_g;
        got = 1'b0;
        g   = 1'b0;
        apply_reqs();
        exp_g = (pend[0] && pend[1]) ? ~m_last : pend[1];
        #1;
        for (int t = 0; t < 20; t++) begin
            if ((req_valid & req_ready) != 2'b00) begin
                got = 1'b1;
                g   = req_ready[1];
                break;
            end
            @(negedge lpc_clock);
            #1;
        end
        check("accept", 32'(got), 32'd1);
        if (!got)
            return;
        check("grant", 32'(g), 32'(exp_g));
        m_last = g;
        build(int'(g));
        @(posedge lpc_clock);
        #1;
        pend[g] = 1'b0;
        apply_reqs();
        for (int k = 0; k < exp_q.size(); k++) begin
            lpc_ad_in = in_q[k];
            @(negedge lpc_clock);
            check("bus", 32'(bus_now()), 32'(exp_q[k]));
            check("ready_busy", 32'(req_ready), 32'd0);
            check("rsp_quiet", 32'(rsp_valid), 32'd0);
            check("rsp_hold", {rsp_id, rsp_err, rsp_rdata},
                  {h_id, h_err, h_rdata});
            if (k + 1 == kill_at) begin
                lpc_reset = 1'b0;
                #1;
                check("kill_bus", 32'(bus_now()), 32'h20);
                check("kill_ad", 32'(lpc_ad_out), 32'hF);
                check("kill_rsp", 32'(rsp_valid), 32'd0);
                pend[0] = 1'b0;
                pend[1] = 1'b0;
                apply_reqs();
                m_last  = 1'b1;
                h_id    = 1'b0;
                h_err   = 1'b0;
                h_rdata = 8'h00;
                lpc_ad_in = 4'hF;
                for (int j = 0; j < 2; j++) begin
                    @(negedge lpc_clock);
                    check("kill_norsp", 32'(rsp_valid), 32'd0);
                end
                lpc_reset = 1'b1;
                return;
            end
            @(posedge lpc_clock);
            #1;
        end
        lpc_ad_in = 4'hF;
        @(negedge lpc_clock);
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_id", 32'(rsp_id), 32'(g));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
        check("idle_bus", 32'(bus_now()), 32'h20);
        h_id    = g;
        h_err   = exp_err;
        h_rdata = exp_rdata;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        lpc_reset = 1'b0;
        lpc_ad_in = 4'hF;
        for (int g = 0; g < 2; g++) begin
            pend[g]   = 1'b0;
            m_mem[g]  = 1'b0;
            m_wr[g]   = 1'b0;
            m_addr[g] = '0;
            m_wd[g]   = '0;
        end
        m_last  = 1'b1;
        h_id    = 1'b0;
        h_err   = 1'b0;
        h_rdata = 8'h00;
        rd0     = 4'h0;
        rd1     = 4'h0;
        apply_reqs();
        repeat (3) @(negedge lpc_clock);
        check("rst_frame", 32'(lpc_frame), 32'd1);
        check("rst_ad", 32'(lpc_ad_out), 32'hF);
        check("rst_oe", 32'(lpc_ad_oe), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        lpc_reset = 1'b1;

        set_req(0, 1'b0, 1'b1, 32'h0000_0080, 8'h5A);
        sync_q = '{4'h0};
        run_txn(0);

        set_req(1, 1'b0, 1'b0, 32'h0000_002E, 8'h00);
        sync_q = '{4'h6, 4'h6, 4'h6, 4'h0};
        rd0 = 4'h5;
        rd1 = 4'hA;
        run_txn(0);

        set_req(0, 1'b0, 1'b0, 32'h0000_0064, 8'h00);
        sync_q = '{4'hA};
        rd0 = 4'h3;
        rd1 = 4'hC;
        run_txn(0);

        set_req(1, 1'b1, 1'b1, 32'hFFFF_FFF0, 8'h9E);
        sync_q = '{4'h0};
        run_txn(0);

        set_req(0, 1'b0, 1'b0, 32'h0000_0060, 8'h00);
        sync_q.delete();
        for (int i = 0; i < TMO; i++)
            sync_q.push_back(4'hF);
        run_txn(0);

        set_req(1, 1'b1, 1'b0, 32'h1234_5678, 8'h00);
        sync_q = '{4'h0};
        run_txn(3);

        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < 2; g++)
                if (!pend[g])
                    random_req(g);
            random_sync();
            run_txn(0);
        end

        for (int i = 0; i < 30; i++) begin
            for (int g = 0; g < 2; g++)
                if (!pend[g] && $urandom_range(0, 1) == 1)
                    random_req(g);
            if (!pend[0] && !pend[1])
                random_req($urandom_range(0, 1));
            random_sync();
            run_txn(0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
